// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port, watermarks and sticky error flags
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_TH      = 6,
  parameter int AE_TH      = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_accept, rd_accept;

  // Status flags look only at the registered occupancy, never at this cycle's requests.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_TH));
  assign almost_empty = (count_q <= CW'(AE_TH));

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_accept;
    overflow_d  = overflow_q  || (wr_en && full);
    underflow_d = underflow_q || (rd_en && empty);

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + CW'(1);
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - directed self-checking bench for sync_fifo
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int vectors = 0;
  int miscompares = 0;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .AF_TH(6),
    .AE_TH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
    vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %b want 0", almost_full); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL reset_sticky got ovf=%b unf=%b want 0/0", overflow, underflow);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      vectors++; if (count !== 4'(i)) begin miscompares++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i); end
      vectors++; if (almost_full !== (i >= 6)) begin miscompares++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i >= 6)); end
      vectors++; if (full !== (i == 8)) begin miscompares++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i == 8)); end
      vectors++; if (almost_empty !== (i <= 2)) begin miscompares++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i <= 2)); end
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      tick();
      vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d] got %b want 1", i, rd_valid); end
      vectors++; if (rd_data !== 8'(i)) begin miscompares++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, 8'(i)); end
      vectors++; if (count !== 4'(8 - i)) begin miscompares++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 8 - i); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL drain_idle_valid got %b want 0", rd_valid); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", empty); end
    vectors++; if (rd_data !== 8'h08) begin miscompares++; $display("FAIL drain_hold got %h want 08", rd_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_data = 8'hAA;
    tick();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
    vectors++; if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count got %0d want 8", count); end
    rd_en = 1'b1;
    tick();
    vectors++; if (count !== 4'd7) begin miscompares++; $display("FAIL ovf_rw_count got %0d want 7", count); end
    vectors++; if (rd_data !== 8'h11 || rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL ovf_rw_data got %h/%b want 11/1", rd_data, rd_valid);
    end
    wr_en = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      vectors++; if (rd_data !== 8'(8'h10 + i)) begin miscompares++; $display("FAIL ovf_drain[%0d] got %h want %h", i, rd_data, 8'(8'h10 + i)); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL ovf_end got empty=%b ovf=%b want 1/1", empty, overflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    wr_en = 1'b1; wr_data = 8'h5C;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    vectors++; if (rd_data !== 8'h5C) begin miscompares++; $display("FAIL unf_setup got %h want 5c", rd_data); end
    tick();
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_flag got %b want 1", underflow); end
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL unf_valid got %b want 0", rd_valid); end
    vectors++; if (rd_data !== 8'h5C) begin miscompares++; $display("FAIL unf_hold got %h want 5c", rd_data); end
    vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL unf_count got %0d want 0", count); end
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    vectors++; if (rd_valid !== 1'b0 || rd_data !== 8'h5C) begin
      miscompares++; $display("FAIL unf_rw_nofall got %b/%h want 0/5c", rd_valid, rd_data);
    end
    vectors++; if (count !== 4'd1) begin miscompares++; $display("FAIL unf_rw_count got %0d want 1", count); end
    wr_en = 1'b0;
    tick();
    vectors++; if (rd_data !== 8'h77 || rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL unf_rw_read got %h/%b want 77/1", rd_data, rd_valid);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'(3 + k);
      tick();
      vectors++; if (count !== 4'd3) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d want 3", k, count); end
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 8'(k)) begin
        miscompares++; $display("FAIL b2b_data[%0d] got %h/%b want %h/1", k, rd_data, rd_valid, 8'(k));
      end
    end
    wr_en = 1'b0;
    for (int k = 20; k < 23; k++) begin
      tick();
      vectors++; if (rd_data !== 8'(k)) begin miscompares++; $display("FAIL b2b_tail[%0d] got %h want %h", k, rd_data, 8'(k)); end
    end
    rd_en = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
      tick();
    end
    vectors++; if (count !== 4'd5 || underflow !== 1'b1) begin
      miscompares++; $display("FAIL rmid_setup got cnt=%0d unf=%b want 5/1", count, underflow);
    end
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    vectors++; if (count !== 4'd0 || empty !== 1'b1) begin
      miscompares++; $display("FAIL rmid_count got cnt=%0d empty=%b want 0/1", count, empty);
    end
    vectors++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL rmid_flags got v=%b ovf=%b unf=%b want 0/0/0", rd_valid, overflow, underflow);
    end
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++; if (rd_data !== 8'h3C || rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL rmid_first got %h/%b want 3c/1", rd_data, rd_valid);
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rmid_empty got %b want 1", empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
